// File: rtl/mem_access_unit.sv
// mem_access_unit -- load/store unit bridging the MEM pipeline stage to a
// valid/ready request bus with a separate response channel.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   mem_valid_i, mem_we_i    MEM stage holds an access / access is a store
//   mem_size_i               0=byte, 1=half, 2=word
//   mem_unsigned_i           zero-extend load data
//   mem_addr_i, mem_wdata_i  byte address, LSB-aligned store data
//   flush_mem_i              kill the MEM-stage access
//   req_*                    bus request channel (word-aligned address, byte strobes)
//   resp_*                   bus response channel (data, error)
//   ram_stall_valid_mem_o    stall request to pipeline control
//   rdata_o                  extended load data, valid while done_o is high
//   done_o                   one-cycle access-complete pulse
//   access_fault_o           bus error (or timeout) for the completed access
//
// Optional feature: define LSU_BUS_TIMEOUT_EN to abort an access with a fault
// after 255 cycles without completion in REQ/WAIT.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        flush_mem_i,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic [31:0] req_addr_o,
    output logic        req_we_o,
    output logic [31:0] req_wdata_o,
    output logic [3:0]  req_wstrb_o,
    input  logic        resp_valid_i,
    input  logic [31:0] resp_rdata_i,
    input  logic        resp_err_i,
    output logic        ram_stall_valid_mem_o,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        access_fault_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;
    logic        kill_q;
    logic        fault_q;
    logic [31:0] rdata_q;

    logic        start;      // IDLE -> REQ, capture the access
    logic        resp_take;  // response accepted in WAIT
    logic        to_take;    // timeout ends the access
    logic        timeout;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

`ifdef LSU_BUS_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (start) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_REQ || state_q == S_WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
    end

    assign timeout = (tmo_cnt_q == 8'hFF);
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control outputs
    always_comb begin
        state_d               = state_q;
        start                 = 1'b0;
        resp_take             = 1'b0;
        to_take               = 1'b0;
        req_valid_o           = 1'b0;
        ram_stall_valid_mem_o = 1'b0;
        done_o                = 1'b0;
        access_fault_o        = 1'b0;
        case (state_q)
            S_IDLE: begin
                // rst gates the stall so a reset cycle never holds the pipeline
                if (mem_valid_i && !flush_mem_i && !rst) begin
                    ram_stall_valid_mem_o = 1'b1;
                end
                if (mem_valid_i && !flush_mem_i) begin
                    start   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                req_valid_o           = 1'b1;
                ram_stall_valid_mem_o = 1'b1;
                if (req_ready_i) begin
                    state_d = S_WAIT;
                end else if (timeout) begin
                    to_take = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                ram_stall_valid_mem_o = 1'b1;
                if (resp_valid_i) begin
                    resp_take = 1'b1;
                    state_d   = S_DONE;
                end else if (timeout) begin
                    to_take = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_o         = ~kill_q;
                access_fault_o = fault_q & ~kill_q;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Load lane selection and extension from the live response data
    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = resp_rdata_i[7:0];
            2'd1:    byte_sel = resp_rdata_i[15:8];
            2'd2:    byte_sel = resp_rdata_i[23:16];
            default: byte_sel = resp_rdata_i[31:24];
        endcase
        half_sel = addr_q[1] ? resp_rdata_i[31:16] : resp_rdata_i[15:0];
        case (size_q)
            2'd0:    load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'd1:    load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_ext = resp_rdata_i;
        endcase
    end

    // Captured access fields, kill/fault flags and load data
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            kill_q  <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (start) begin
                addr_q  <= mem_addr_i;
                wdata_q <= mem_wdata_i;
                size_q  <= mem_size_i;
                we_q    <= mem_we_i;
                uns_q   <= mem_unsigned_i;
                kill_q  <= 1'b0;
                fault_q <= 1'b0;
            end else if ((state_q == S_REQ || state_q == S_WAIT) && flush_mem_i) begin
                // the bus transaction still runs to completion; only the result is dropped
                kill_q <= 1'b1;
            end
            if (resp_take) begin
                if (resp_err_i) begin
                    fault_q <= 1'b1;
                    rdata_q <= '0;
                end else if (!we_q) begin
                    rdata_q <= load_ext;
                end
            end else if (to_take) begin
                fault_q <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

    // Request fields come only from captured values
    always_comb begin
        req_addr_o  = {addr_q[31:2], 2'b00};
        req_we_o    = we_q;
        req_wstrb_o = 4'b0000;
        req_wdata_o = wdata_q;
        case (size_q)
            2'd0: begin
                req_wdata_o = {4{wdata_q[7:0]}};
                if (we_q) req_wstrb_o = 4'b0001 << addr_q[1:0];
            end
            2'd1: begin
                req_wdata_o = {2{wdata_q[15:0]}};
                if (we_q) req_wstrb_o = 4'b0011 << {addr_q[1], 1'b0};
            end
            default: begin
                if (we_q) req_wstrb_o = 4'b1111;
            end
        endcase
    end

    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit -- directed self-checking bench for mem_access_unit.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        mem_valid_i;
    logic        mem_we_i;
    logic [1:0]  mem_size_i;
    logic        mem_unsigned_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        flush_mem_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] req_addr_o;
    logic        req_we_o;
    logic [31:0] req_wdata_o;
    logic [3:0]  req_wstrb_o;
    logic        resp_valid_i;
    logic [31:0] resp_rdata_i;
    logic        resp_err_i;
    logic        ram_stall_valid_mem_o;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        access_fault_o;

    int tests = 0;
    int fails = 0;
    int stall_cnt;
    int n;
    logic got_done;
    logic fault_seen;

    mem_access_unit dut (
        .clk                   (clk),
        .rst                   (rst),
        .mem_valid_i           (mem_valid_i),
        .mem_we_i              (mem_we_i),
        .mem_size_i            (mem_size_i),
        .mem_unsigned_i        (mem_unsigned_i),
        .mem_addr_i            (mem_addr_i),
        .mem_wdata_i           (mem_wdata_i),
        .flush_mem_i           (flush_mem_i),
        .req_valid_o           (req_valid_o),
        .req_ready_i           (req_ready_i),
        .req_addr_o            (req_addr_o),
        .req_we_o              (req_we_o),
        .req_wdata_o           (req_wdata_o),
        .req_wstrb_o           (req_wstrb_o),
        .resp_valid_i          (resp_valid_i),
        .resp_rdata_i          (resp_rdata_i),
        .resp_err_i            (resp_err_i),
        .ram_stall_valid_mem_o (ram_stall_valid_mem_o),
        .rdata_o               (rdata_o),
        .done_o                (done_o),
        .access_fault_o        (access_fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access with ready in the first REQ cycle and response in the first WAIT cycle
    task automatic access(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rresp, input logic err,
                          input logic [31:0] e_addr, input logic [31:0] e_wdata,
                          input logic [3:0] e_strb, input logic [31:0] e_rdata,
                          input logic e_fault);
        mem_valid_i    = 1'b1;
        mem_we_i       = we;
        mem_size_i     = size;
        mem_unsigned_i = uns;
        mem_addr_i     = addr;
        mem_wdata_i    = wdata;
        smp();
        chk({tag, "/stall_idle"}, ram_stall_valid_mem_o, 1);
        adv();
        req_ready_i = 1'b1;
        smp();
        chk({tag, "/req_valid"}, req_valid_o, 1);
        chk({tag, "/req_addr"}, req_addr_o, e_addr);
        chk({tag, "/req_we"}, req_we_o, we);
        chk({tag, "/req_wstrb"}, req_wstrb_o, e_strb);
        if (we) chk({tag, "/req_wdata"}, req_wdata_o, e_wdata);
        adv();
        req_ready_i  = 1'b0;
        resp_valid_i = 1'b1;
        resp_rdata_i = rresp;
        resp_err_i   = err;
        smp();
        chk({tag, "/req_valid_wait"}, req_valid_o, 0);
        adv();
        resp_valid_i = 1'b0;
        resp_err_i   = 1'b0;
        mem_valid_i  = 1'b0;
        smp();
        chk({tag, "/done"}, done_o, 1);
        chk({tag, "/stall_done"}, ram_stall_valid_mem_o, 0);
        chk({tag, "/fault"}, access_fault_o, e_fault);
        if (!we || err) chk({tag, "/rdata"}, rdata_o, e_rdata);
        adv();
        smp();
        chk({tag, "/done_after"}, done_o, 0);
        adv();
    endtask

    initial begin
        rst            = 1'b1;
        mem_valid_i    = 1'b1;   // reset must win over a pending access
        mem_we_i       = 1'b0;
        mem_size_i     = 2'd2;
        mem_unsigned_i = 1'b0;
        mem_addr_i     = 32'h0;
        mem_wdata_i    = 32'h0;
        flush_mem_i    = 1'b0;
        req_ready_i    = 1'b0;
        resp_valid_i   = 1'b0;
        resp_rdata_i   = 32'h0;
        resp_err_i     = 1'b0;

        // Reset
        adv();
        adv();
        smp();
        chk("rst/req_valid", req_valid_o, 0);
        chk("rst/done", done_o, 0);
        chk("rst/fault", access_fault_o, 0);
        chk("rst/rdata", rdata_o, 0);
        chk("rst/stall", ram_stall_valid_mem_o, 0);
        adv();
        rst         = 1'b0;
        mem_valid_i = 1'b0;
        adv();

        // Word load: ready in second REQ cycle, response in third WAIT cycle
        stall_cnt      = 0;
        mem_valid_i    = 1'b1;
        mem_size_i     = 2'd2;
        mem_addr_i     = 32'h8000_0004;
        smp(); stall_cnt += int'(ram_stall_valid_mem_o);
        chk("wl/req_valid_idle", req_valid_o, 0);
        adv();
        smp(); stall_cnt += int'(ram_stall_valid_mem_o);
        chk("wl/req_valid", req_valid_o, 1);
        chk("wl/req_addr", req_addr_o, 32'h8000_0004);
        chk("wl/wstrb", req_wstrb_o, 4'b0000);
        adv();
        req_ready_i = 1'b1;
        smp(); stall_cnt += int'(ram_stall_valid_mem_o);
        chk("wl/req_valid_held", req_valid_o, 1);
        adv();
        req_ready_i = 1'b0;
        smp(); stall_cnt += int'(ram_stall_valid_mem_o);
        chk("wl/req_valid_wait", req_valid_o, 0);
        adv();
        smp(); stall_cnt += int'(ram_stall_valid_mem_o);
        adv();
        resp_valid_i = 1'b1;
        resp_rdata_i = 32'hDEAD_BEEF;
        smp(); stall_cnt += int'(ram_stall_valid_mem_o);
        adv();
        resp_valid_i = 1'b0;
        mem_valid_i  = 1'b0;
        smp(); stall_cnt += int'(ram_stall_valid_mem_o);
        chk("wl/done", done_o, 1);
        chk("wl/rdata", rdata_o, 32'hDEAD_BEEF);
        chk("wl/fault", access_fault_o, 0);
        chk("wl/stall_cycles", stall_cnt, 6);
        adv();
        smp();
        chk("wl/done_pulse", done_o, 0);
        chk("wl/rdata_held", rdata_o, 32'hDEAD_BEEF);
        adv();

        //      tag     we    sz    uns   addr           wdata          resp           err   e_addr         e_wdata        strb     e_rdata        fault
        access("lb",   1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0,         32'h80FF_FFFF, 1'b0, 32'h8000_0000, 32'h0,         4'b0000, 32'hFFFF_FF80, 1'b0);
        access("lbu",  1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0,         32'h80FF_FFFF, 1'b0, 32'h8000_0000, 32'h0,         4'b0000, 32'h0000_0080, 1'b0);
        access("lh",   1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'h0,         32'h8001_1234, 1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'hFFFF_8001, 1'b0);
        access("lhu",  1'b0, 2'd1, 1'b1, 32'h0000_0000, 32'h0,         32'hABCD_9876, 1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'h0000_9876, 1'b0);
        access("sw",   1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h0102_0304, 32'h0,         1'b0, 32'h0000_0100, 32'h0102_0304, 4'b1111, 32'h0,         1'b0);
        access("sh",   1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'h1234_ABCD, 32'h0,         1'b0, 32'h0000_0000, 32'hABCD_ABCD, 4'b1100, 32'h0,         1'b0);
        access("sb",   1'b1, 2'd0, 1'b0, 32'h0000_0007, 32'hFFFF_FFA5, 32'h0,         1'b0, 32'h0000_0004, 32'hA5A5_A5A5, 4'b1000, 32'h0,         1'b0);
        access("lerr", 1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'h0,         32'h0000_0055, 1'b1, 32'h0000_0008, 32'h0,         4'b0000, 32'h0,         1'b1);

        // Flush in IDLE: no access starts; stray response in IDLE is ignored
        mem_valid_i  = 1'b1;
        flush_mem_i  = 1'b1;
        resp_valid_i = 1'b1;
        smp();
        chk("fidle/stall", ram_stall_valid_mem_o, 0);
        adv();
        mem_valid_i  = 1'b0;
        flush_mem_i  = 1'b0;
        resp_valid_i = 1'b0;
        smp();
        chk("fidle/req_valid", req_valid_o, 0);
        chk("fidle/done", done_o, 0);
        adv();

        // Flush in REQ with a bus error: access finishes silently
        mem_valid_i = 1'b1;
        mem_we_i    = 1'b0;
        mem_size_i  = 2'd2;
        mem_addr_i  = 32'h0000_0040;
        adv();
        flush_mem_i  = 1'b1;
        resp_valid_i = 1'b1;     // outside WAIT, must not complete the access
        resp_err_i   = 1'b1;
        smp();
        chk("freq/stall", ram_stall_valid_mem_o, 1);
        adv();
        flush_mem_i  = 1'b0;
        resp_valid_i = 1'b0;
        resp_err_i   = 1'b0;
        req_ready_i  = 1'b1;
        smp();
        chk("freq/req_valid_held", req_valid_o, 1);
        adv();
        req_ready_i  = 1'b0;
        resp_valid_i = 1'b1;
        resp_err_i   = 1'b1;
        adv();
        resp_valid_i = 1'b0;
        resp_err_i   = 1'b0;
        mem_valid_i  = 1'b0;
        smp();
        chk("freq/done", done_o, 0);
        chk("freq/fault", access_fault_o, 0);
        chk("freq/stall_done", ram_stall_valid_mem_o, 0);
        adv();

        // Flush pulse in WAIT, then a normal access
        mem_valid_i = 1'b1;
        mem_addr_i  = 32'h0000_0044;
        adv();
        req_ready_i = 1'b1;
        adv();
        req_ready_i = 1'b0;
        flush_mem_i = 1'b1;
        smp();
        chk("fwait/stall_wait", ram_stall_valid_mem_o, 1);
        adv();
        flush_mem_i  = 1'b0;
        resp_valid_i = 1'b1;
        resp_rdata_i = 32'hCAFE_F00D;
        smp();
        chk("fwait/stall_wait2", ram_stall_valid_mem_o, 1);
        adv();
        resp_valid_i = 1'b0;
        mem_valid_i  = 1'b0;
        smp();
        chk("fwait/done", done_o, 0);
        chk("fwait/stall_done", ram_stall_valid_mem_o, 0);
        adv();
        access("after_flush", 1'b0, 2'd0, 1'b0, 32'h0000_0001, 32'h0, 32'h1122_3344, 1'b0,
               32'h0000_0000, 32'h0, 4'b0000, 32'h0000_0033, 1'b0);

        // Reset in WAIT; late response afterwards is ignored
        mem_valid_i = 1'b1;
        mem_size_i  = 2'd2;
        mem_addr_i  = 32'h0000_0010;
        adv();
        req_ready_i = 1'b1;
        adv();
        req_ready_i = 1'b0;
        rst         = 1'b1;
        mem_valid_i = 1'b0;
        adv();
        rst = 1'b0;
        smp();
        chk("rwait/req_valid", req_valid_o, 0);
        chk("rwait/done", done_o, 0);
        chk("rwait/fault", access_fault_o, 0);
        chk("rwait/rdata", rdata_o, 0);
        chk("rwait/stall", ram_stall_valid_mem_o, 0);
        adv();
        resp_valid_i = 1'b1;
        resp_rdata_i = 32'h1234_5678;
        adv();
        resp_valid_i = 1'b0;
        smp();
        chk("rwait/late_done", done_o, 0);
        chk("rwait/late_rdata", rdata_o, 0);
        chk("rwait/late_req_valid", req_valid_o, 0);
        adv();
        access("post_rst", 1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'h0, 32'h0BAD_F00D, 1'b0,
               32'h0000_000C, 32'h0, 4'b0000, 32'h0BAD_F00D, 1'b0);

        // Long stall with req_ready_i low
        mem_valid_i = 1'b1;
        mem_size_i  = 2'd2;
        mem_addr_i  = 32'h0000_0020;
        adv();
        n          = 0;
        got_done   = 1'b0;
        fault_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            smp();
            if (req_valid_o) n++;
            if (done_o) begin
                got_done   = 1'b1;
                fault_seen = access_fault_o;
                break;
            end
            adv();
        end
`ifdef LSU_BUS_TIMEOUT_EN
        chk("tmo/req_cycles", n, 256);
        chk("tmo/done", got_done, 1);
        chk("tmo/fault", fault_seen, 1);
        chk("tmo/rdata", rdata_o, 0);
        mem_valid_i = 1'b0;
        adv();
`else
        chk("notmo/req_cycles", n, 300);
        chk("notmo/done", got_done, 0);
        req_ready_i = 1'b1;
        adv();
        req_ready_i  = 1'b0;
        resp_valid_i = 1'b1;
        resp_rdata_i = 32'h7654_3210;
        adv();
        resp_valid_i = 1'b0;
        mem_valid_i  = 1'b0;
        smp();
        chk("notmo/done_end", done_o, 1);
        chk("notmo/rdata", rdata_o, 32'h7654_3210);
        adv();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous reset, active-high.
REQ-003 SHALL have ports: mem_valid_i  in  1  MEM stage holds a load/store; mem_we_i  in  1  1=store; mem_size_i  in  2  0=byte,1=half,2=word; mem_unsigned_i  in  1  zero-extend load.
REQ-004 SHALL have ports: mem_addr_i  in  32  byte address; mem_wdata_i  in  32  store data (LSB-aligned).
REQ-005 SHALL have ports: flush_mem_i  in  1  MEM-stage flush from pipeline control.
REQ-006 SHALL have ports: req_valid_o  out  1; req_ready_i  in  1; req_addr_o  out  32 (word-aligned); req_we_o  out  1; req_wdata_o  out  32; req_wstrb_o  out  4.
REQ-007 SHALL have ports: resp_valid_i  in  1; resp_rdata_i  in  32; resp_err_i  in  1.
REQ-008 SHALL have ports: ram_stall_valid_mem_o  out  1  stall request to pipeline control; rdata_o  out  32  extended load data; done_o  out  1  access complete; access_fault_o  out  1  bus error/timeout.

Function
REQ-009 SHALL implement FSM IDLE, REQ, WAIT, DONE; IDLE->REQ when mem_valid_i; REQ->WAIT on req_valid_o&req_ready_i; WAIT->DONE on resp_valid_i; DONE->IDLE unconditionally.
REQ-010 SHALL drive ram_stall_valid_mem_o = (IDLE & mem_valid_i & ~flush_mem_i) | REQ | WAIT; deasserted in DONE so the pipeline advances exactly once per access.
REQ-011 SHALL register address, size, we, unsigned, wdata on IDLE->REQ; bus outputs driven only from registered values.
REQ-012 SHALL hold req_valid_o high and request fields stable in REQ until req_ready_i; never drop valid before handshake.
REQ-013 SHALL form req_wstrb_o: byte 4'b0001<<a[1:0]; half 4'b0011<<{a[1],1'b0}; word 4'b1111; loads 4'b0000.
REQ-014 SHALL replicate store data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
REQ-015 SHALL select load byte/half by a[1:0] from captured resp_rdata_i, sign-extend unless mem_unsigned_i, register into rdata_o.
REQ-016 SHALL pulse done_o one cycle in DONE; rdata_o valid in DONE, held until next capture.
REQ-017 SHALL set access_fault_o in DONE when resp_err_i was sampled with resp_valid_i; rdata_o then 0.
REQ-018 SHALL on flush_mem_i in IDLE not start an access; in REQ/WAIT set kill flag, finish bus transaction, suppress done_o/access_fault_o in DONE, keep stall asserted until DONE.
REQ-019 SHALL treat misaligned half/word (a[0] or a[1:0]!=0) as not checked; alignment is upstream's duty; req_addr_o = {a[31:2],2'b00}.
REQ-020 SHALL ignore resp_valid_i outside WAIT.

Reset
REQ-021 SHALL on rst: state IDLE, kill flag 0, req_valid_o 0, done_o 0, access_fault_o 0, rdata_o 0, stall 0; any in-flight transaction abandoned.
REQ-022 SHALL give rst priority over all other inputs in the same cycle.

Configuration
REQ-023 SHALL with LSU_BUS_TIMEOUT_EN defined include an 8-bit counter cleared on entering REQ, incremented in REQ/WAIT; at 255 go DONE with access_fault_o=1 (unless killed).
REQ-024 SHALL without LSU_BUS_TIMEOUT_EN omit the counter; REQ/WAIT wait indefinitely.

Verification
REQ-025 Word load a=0x80000004, ready after 2 cycles, resp 3 cycles later data 0xDEADBEEF -> stall high 6 cycles, done_o one cycle, rdata_o=0xDEADBEEF.
REQ-026 Signed byte load a=0x80000003, resp 0x80FF_FFFF -> req_addr_o=0x80000000, wstrb 0000, rdata_o=0xFFFFFF80; unsigned -> 0x00000080.
REQ-027 Half store a=0x2, d=0x1234ABCD -> req_wdata_o=0xABCDABCD, req_wstrb_o=1100, req_we_o=1.
REQ-028 flush_mem_i pulse in WAIT -> transaction completes, done_o stays 0, stall drops in DONE, next access starts normally.
REQ-029 resp_err_i=1 with resp_valid_i -> access_fault_o=1, rdata_o=0; with LSU_BUS_TIMEOUT_EN and req_ready_i never high -> fault after 255 cycles in REQ.
REQ-030 rst asserted in WAIT -> next cycle all outputs 0, state IDLE, late resp_valid_i ignored.
